// File: rtl/pipeline_register_elastic.sv
// ---------------------------------------------------------------------------
// pipeline_register_elastic
//
// Configurable elastic pipeline register placed between two CPU pipeline
// stages. DEPTH register stages carry a packed DATA_WIDTH bundle. Each stage
// has its own valid bit. Empty stages collapse (bubble removal), so an empty
// slot always pulls from its predecessor, even while the output is blocked.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. in_ready_o depends combinationally on
// out_ready_i through the chain of move signals. This lets a full chain
// accept a new bundle in the same cycle that it hands one downstream.
//
// Control priority: reset > flush > stall > normal advance.
//   flush : clears every valid bit. Data bits selected by FLUSH_MASK are
//           zeroed. No input or output transfer completes.
//   stall : freezes every stage. No input or output transfer completes.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (clears valid, data, count)
//   stall_i      freeze all stages
//   flush_i      invalidate all stages (honoured when FLUSH_ENABLE != 0)
//   in_valid_i   upstream offers data_i
//   in_ready_o   chain accepts data_i this cycle
//   data_i       upstream bundle
//   out_valid_o  last stage holds a valid bundle
//   out_ready_i  downstream consumes the last stage this cycle
//   data_o       last-stage bundle (driven regardless of out_valid_o)
//   occupancy_o  number of valid stages (registered)
// ---------------------------------------------------------------------------
module pipeline_register_elastic #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    DEPTH        = 2,
    parameter int                    FLUSH_ENABLE = 1,
    parameter logic [DATA_WIDTH-1:0] FLUSH_MASK   = {DATA_WIDTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      v;
    logic [DATA_WIDTH-1:0] d [DEPTH];

    // free[k]: stage k may hand its contents forward this cycle.
    // free[DEPTH-1] is the downstream ready.
    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] move;
    logic             free_in;
    logic             flush_act;
    logic             active;
    logic             in_hs;
    logic             out_hs;

    assign flush_act = flush_i & (FLUSH_ENABLE != 0);
    assign active    = !stall_i & !flush_act;

    // Move chain, evaluated from the output side back towards the input.
    always_comb begin
        free = '0;
        move = '0;
        free[DEPTH-1] = out_ready_i;
        move[DEPTH-1] = v[DEPTH-1] & out_ready_i;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            free[k] = !v[k+1] | move[k+1];
            move[k] = v[k] & free[k];
        end
    end

    assign free_in    = !v[0] | move[0];
    assign in_ready_o = active & free_in;
    assign in_hs      = in_valid_i & in_ready_o;
    assign out_hs     = active & move[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            v           <= '0;
            occupancy_o <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush_act) begin
            v           <= '0;
            occupancy_o <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= d[k] & ~FLUSH_MASK;
            end
        end else if (!stall_i) begin
            // Stage 0 is free whenever it is empty or moving on. Without a new
            // input it simply goes invalid, and its data holds.
            if (free_in) begin
                v[0] <= in_valid_i;
                if (in_valid_i) begin
                    d[0] <= data_i;
                end
            end
            // A load copies the predecessor, including an invalid one. This
            // is how bubbles move forward and collapse.
            for (int k = 1; k < DEPTH; k++) begin
                if (free[k-1]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
            // A stage at the output that empties without reload is covered by
            // the loop above (it copies v[DEPTH-2]). For DEPTH=1 it is covered
            // by stage 0 logic.
            case ({in_hs, out_hs})
                2'b10:   occupancy_o <= occupancy_o + OCC_W'(1);
                2'b01:   occupancy_o <= occupancy_o - OCC_W'(1);
                default: occupancy_o <= occupancy_o;
            endcase
        end
    end

    assign out_valid_o = v[DEPTH-1];
    assign data_o      = d[DEPTH-1];

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Bench for pipeline_register_elastic (DEPTH=2, DATA_WIDTH=8, FLUSH_MASK=8'h0F).
// A second instance with FLUSH_ENABLE=0 shares every input.
module tb_pipeline_register_elastic;

    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] data = '0;
    logic         out_ready = 1'b0;

    logic         in_ready, out_valid;
    logic [W-1:0] data_out;
    logic [1:0]   occ;

    logic         nf_in_ready, nf_out_valid;
    logic [W-1:0] nf_data_out;
    logic [1:0]   nf_occ;

    pipeline_register_elastic #(
        .DATA_WIDTH(W), .DEPTH(2), .FLUSH_ENABLE(1), .FLUSH_MASK(8'h0F)
    ) u_dut (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(data_out),
        .occupancy_o(occ)
    );

    pipeline_register_elastic #(
        .DATA_WIDTH(W), .DEPTH(2), .FLUSH_ENABLE(0), .FLUSH_MASK(8'h0F)
    ) u_nf (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(nf_in_ready), .data_i(data),
        .out_valid_o(nf_out_valid), .out_ready_i(out_ready), .data_o(nf_data_out),
        .occupancy_o(nf_occ)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the main instance. Accepted inputs are pushed, and
    // output transfers are popped and compared. A flush or reset discards
    // everything in flight.
    always @(negedge clk) begin
        check("occ_model", 32'(occ), 32'(exp_q.size()));
        if (reset || flush) begin
            exp_q.delete();
        end else if (!stall) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_underflow", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && occ != 0; i++) next_cycle();
        check("drain_empty", 32'(occ), 0);
    endtask

    initial begin
        // ---- 1. reset and streaming ----
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_data_o", 32'(data_out), 0);
        check("rst_occ", 32'(occ), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        next_cycle();

        out_ready = 1'b1;
        in_valid = 1'b1; data = 8'hA1;
        @(negedge clk);
        check("s1_in_ready", 32'(in_ready), 1);
        check("s1_lat0", 32'(out_valid), 0);
        next_cycle();
        data = 8'hB2;
        @(negedge clk);
        check("s1_lat1", 32'(out_valid), 0);
        next_cycle();
        data = 8'hC3;
        @(negedge clk);
        check("s1_lat2_valid", 32'(out_valid), 1);
        check("s1_lat2_data", 32'(data_out), 32'hA1);
        check("s1_occ", 32'(occ), 2);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("s1_occ_steady", 32'(occ), 2);
        next_cycle();
        drain();

        // ---- 2. backpressure ----
        out_ready = 1'b0;
        in_valid = 1'b1; data = 8'h11;
        next_cycle();
        data = 8'h22;
        @(negedge clk);
        check("bp_in_ready_2nd", 32'(in_ready), 1);
        next_cycle();
        data = 8'h33;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_full_ready", 32'(in_ready), 0);
            check("bp_full_occ", 32'(occ), 2);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 1);
        check("bp_release_data", 32'(data_out), 32'h11);
        next_cycle();
        drain();

        // ---- 3. bubble collapse ----
        out_ready = 1'b0;
        in_valid = 1'b1; data = 8'h55;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        in_valid = 1'b1; data = 8'h66;
        @(negedge clk);
        check("bub_in_ready", 32'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("bub_occ", 32'(occ), 2);
        check("bub_out_valid", 32'(out_valid), 1);
        check("bub_data", 32'(data_out), 32'h55);

        // ---- 4. stall while full ----
        next_cycle();
        stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_data", 32'(data_out), 32'h55);
            check("stall_occ", 32'(occ), 2);
            next_cycle();
        end
        stall = 1'b0;
        drain();

        // ---- 5. flush with mask ----
        out_ready = 1'b0;
        in_valid = 1'b1; data = 8'hAB;
        next_cycle();
        data = 8'hFF;
        next_cycle();
        flush = 1'b1; data = 8'h12;
        @(negedge clk);
        check("fl_in_ready", 32'(in_ready), 0);
        check("nf_fl_in_ready", 32'(nf_in_ready), 0);
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_occ", 32'(occ), 0);
        check("fl_data_masked", 32'(data_out), 32'hA0);
        check("nf_out_valid", 32'(nf_out_valid), 1);
        check("nf_data", 32'(nf_data_out), 32'hAB);
        check("nf_occ", 32'(nf_occ), 2);
        next_cycle();
        @(negedge clk);
        check("fl_no_capture_occ", 32'(occ), 0);
        check("fl_no_capture_valid", 32'(out_valid), 0);
        next_cycle();

        // ---- 6. priority ----
        in_valid = 1'b1; data = 8'h01;
        next_cycle();
        data = 8'h02;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("pr_full_occ", 32'(occ), 2);
        next_cycle();
        reset = 1'b1; flush = 1'b1; stall = 1'b1;
        next_cycle();
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1; data = 8'h3C;
        @(negedge clk);
        check("pr_rst_valid", 32'(out_valid), 0);
        check("pr_rst_data", 32'(data_out), 0);
        check("pr_rst_occ", 32'(occ), 0);
        check("pr_rst_nf_data", 32'(nf_data_out), 0);
        check("pr_rst_in_ready", 32'(in_ready), 1);
        next_cycle();
        data = 8'h5A;
        next_cycle();
        in_valid = 1'b0; flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        check("pr_fs_in_ready", 32'(in_ready), 0);
        next_cycle();
        flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("pr_fs_valid", 32'(out_valid), 0);
        check("pr_fs_occ", 32'(occ), 0);
        check("pr_fs_data", 32'(data_out), 32'h30);
        next_cycle();

        drain();
        @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
